// File: rtl/ripple_carry_adder.sv
// Registered ripple-carry adder built from one full-adder cell per bit.
// Define RCA_FLAGS_EN to add registered zero/neg/ovf flag outputs.

module rca_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic             inc,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             outc,
    output logic             out_valid
`ifdef RCA_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;

    assign c[0] = inc;

    // The carry chain deliberately stays a pure ripple so the timing path is exactly WIDTH cells.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        rca_full_adder u_fa (
            .a  (ina[i]),
            .b  (inb[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            outc      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out  <= sum;
                outc <= c[WIDTH];
            end
        end
    end

`ifdef RCA_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero <= 1'b0;
            neg  <= 1'b0;
            ovf  <= 1'b0;
        end else if (in_valid) begin
            zero <= (sum == '0);
            neg  <= sum[WIDTH-1];
            ovf  <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder (WIDTH=8 and WIDTH=16 instances).
// Flag checks are compiled in only when RCA_FLAGS_EN is defined.

module tb_ripple_carry_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  ina8 = '0, inb8 = '0, out8;
    logic        inc8 = 1'b0, inv8 = 1'b0, outc8, outv8;
    logic [15:0] ina16 = '0, inb16 = '0, out16;
    logic        inc16 = 1'b0, inv16 = 1'b0, outc16, outv16;
`ifdef RCA_FLAGS_EN
    logic        zero8, neg8, ovf8, zero16, neg16, ovf16;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ripple_carry_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .ina       (ina8),
        .inb       (inb8),
        .inc       (inc8),
        .in_valid  (inv8),
        .out       (out8),
        .outc      (outc8),
        .out_valid (outv8)
`ifdef RCA_FLAGS_EN
        ,
        .zero      (zero8),
        .neg       (neg8),
        .ovf       (ovf8)
`endif
    );

    ripple_carry_adder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .ina       (ina16),
        .inb       (inb16),
        .inc       (inc16),
        .in_valid  (inv16),
        .out       (out16),
        .outc      (outc16),
        .out_valid (outv16)
`ifdef RCA_FLAGS_EN
        ,
        .zero      (zero16),
        .neg       (neg16),
        .ovf       (ovf16)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({outc8, out8, outv8} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got outc=%b out=%0d valid=%b, want 0 0 0", outc8, out8, outv8);
        end
        checks++;
        if ({outc16, out16, outv16} !== 18'b0) begin
            errors++;
            $display("[TB] FAIL reset_state16: got outc=%b out=%0d valid=%b, want 0 0 0", outc16, out16, outv16);
        end
`ifdef RCA_FLAGS_EN
        checks++;
        if ({zero8, neg8, ovf8} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b%b%b, want 000", zero8, neg8, ovf8);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    // Directed vectors applied back to back, one result checked per cycle.
    task automatic test_directed();
        logic [7:0] va [8] = '{8'd10, 8'd120, 8'd120, 8'd255, 8'd255, 8'd0, 8'd127, 8'd128};
        logic [7:0] vb [8] = '{8'd15, 8'd111, 8'd111, 8'd0,   8'd255, 8'd0, 8'd1,   8'd128};
        logic       vc [8] = '{1'b0,  1'b0,   1'b1,   1'b1,   1'b1,   1'b0, 1'b0,   1'b0};
        logic [7:0] es [8] = '{8'd25, 8'd231, 8'd232, 8'd0,   8'd255, 8'd0, 8'd128, 8'd0};
        logic       ec [8] = '{1'b0,  1'b0,   1'b0,   1'b1,   1'b1,   1'b0, 1'b0,   1'b1};
        logic [2:0] ef [8] = '{3'b000, 3'b011, 3'b011, 3'b100, 3'b010, 3'b100, 3'b011, 3'b101};
        for (int i = 0; i < 8; i++) begin
            ina8 = va[i]; inb8 = vb[i]; inc8 = vc[i]; inv8 = 1'b1;
            tick();
            checks++;
            if (out8 !== es[i] || outc8 !== ec[i] || outv8 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL directed[%0d]: got outc=%b out=%0d valid=%b, want outc=%b out=%0d valid=1",
                         i, outc8, out8, outv8, ec[i], es[i]);
            end
`ifdef RCA_FLAGS_EN
            checks++;
            if ({zero8, neg8, ovf8} !== ef[i]) begin
                errors++;
                $display("[TB] FAIL directed_flags[%0d]: got zno=%b%b%b, want %b", i, zero8, neg8, ovf8, ef[i]);
            end
`endif
        end
        inv8 = 1'b0;
    endtask

    task automatic test_hold();
        ina8 = 8'd200; inb8 = 8'd100; inc8 = 1'b0; inv8 = 1'b1;
        tick();
        checks++;
        if (out8 !== 8'd44 || outc8 !== 1'b1 || outv8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_load: got outc=%b out=%0d valid=%b, want 1 44 1", outc8, out8, outv8);
        end
        for (int i = 0; i < 3; i++) begin
            inv8 = 1'b0;
            if (i == 1) begin
                ina8 = 'x; inb8 = 'x; inc8 = 1'bx;
            end else begin
                ina8 = 8'($urandom); inb8 = 8'($urandom); inc8 = 1'($urandom);
            end
            tick();
            checks++;
            if (out8 !== 8'd44 || outc8 !== 1'b1 || outv8 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold[%0d]: got outc=%b out=%0d valid=%b, want 1 44 0", i, outc8, out8, outv8);
            end
        end
    endtask

    task automatic test_async_reset();
        ina8 = 8'd3; inb8 = 8'd4; inc8 = 1'b0; inv8 = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({outc8, out8, outv8} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got outc=%b out=%0d valid=%b, want 0 0 0", outc8, out8, outv8);
        end
        // Hold reset across an edge with valid operands so the in-flight result is discarded.
        tick();
        checks++;
        if ({outc8, out8, outv8} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_discard: got outc=%b out=%0d valid=%b, want 0 0 0", outc8, out8, outv8);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (out8 !== 8'd7 || outc8 !== 1'b0 || outv8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset: got outc=%b out=%0d valid=%b, want 0 7 1", outc8, out8, outv8);
        end
        inv8 = 1'b0;
    endtask

    task automatic test_random8();
        logic [8:0] exp;
        int         shown = 0;
        for (int i = 0; i < 10000; i++) begin
            ina8 = 8'($urandom); inb8 = 8'($urandom); inc8 = 1'($urandom); inv8 = 1'b1;
            exp = 9'(ina8) + 9'(inb8) + 9'(inc8);
            tick();
            checks++;
            if ({outc8, out8} !== exp || outv8 !== 1'b1) begin
                errors++;
                if (shown++ < 10)
                    $display("[TB] FAIL random8[%0d]: got %0d valid=%b, want %0d valid=1", i, {outc8, out8}, outv8, exp);
            end
        end
        inv8 = 1'b0;
    endtask

    task automatic test_random16();
        logic [16:0] exp;
        int          shown = 0;
        for (int i = 0; i < 10000; i++) begin
            ina16 = 16'($urandom); inb16 = 16'($urandom); inc16 = 1'($urandom); inv16 = 1'b1;
            if (i == 0) begin
                ina16 = 16'hFFFF; inb16 = 16'h0000; inc16 = 1'b1;
            end
            exp = 17'(ina16) + 17'(inb16) + 17'(inc16);
            tick();
            checks++;
            if ({outc16, out16} !== exp || outv16 !== 1'b1) begin
                errors++;
                if (shown++ < 10)
                    $display("[TB] FAIL random16[%0d]: got %0d valid=%b, want %0d valid=1", i, {outc16, out16}, outv16, exp);
            end
        end
        inv16 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_async_reset();
        test_random8();
        test_random16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
